kdf_session_scheduler: RTL and testbench
========================================

Name: kdf_session_scheduler

Overview:
- Shares one `kdf` instance among NUM_REQ session requesters (host channels) using round-robin arbitration.
- For each grant it muxes the requester's operands onto the KDF, pulses `kdf_start` and waits for `kdf_complete`. It then stores the derived key in a per-requester key table and signals done.
- A watchdog covers a hung KDF. A registered read port serves keys to the crypto datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT, 64, cycles allowed from `kdf_start` to `kdf_complete` before error.

Ports:
- clk  in  1  clock.
- reset_n  in  1  async active-low reset.
- req  in  NUM_REQ  level request, one bit per requester; held until `done[i]`.
- req_secret  in  NUM_REQ*256  packed shared secrets; slice i = bits [256*i +: 256].
- req_nonce_fpga  in  NUM_REQ*256  packed FPGA nonces.
- req_nonce_client  in  NUM_REQ*256  packed client nonces.
- done  out  NUM_REQ  one-cycle pulse: key i stored.
- err  out  NUM_REQ  one-cycle pulse: request i timed out.
- key_valid  out  NUM_REQ  key table entry i holds a valid key.
- rd_idx  in  3  key table read index.
- rd_key  out  256  registered key at `rd_idx` (1-cycle latency).
- kdf_start  out  1  start pulse to KDF.
- kdf_shared_secret / kdf_nonce_fpga / kdf_nonce_client  out  256 each  operands to KDF.
- kdf_session_key  in  256  KDF result.
- kdf_complete  in  1  KDF done level.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- **Clock and reset:** clock `clk`; reset `reset_n` is asynchronous and active-low.
- **Reset values:** all outputs 0, key table zeroed, `key_valid` = 0, round-robin pointer = 0, state IDLE.
- **FSM states:** IDLE, LAUNCH, SETTLE, WAIT, STORE.
- **IDLE:**
  - If any `req` bit is set, grant the first set bit at or after the pointer, wrapping modulo NUM_REQ.
  - Latch the grant index and the three operand slices into operand registers, then go to LAUNCH.
  - Requests are sampled only in IDLE.
- **LAUNCH:** `kdf_start` = 1 for exactly this cycle; clear the watchdog; go to SETTLE.
- **SETTLE:** one cycle in which `kdf_complete` is ignored, because the KDF still shows the previous completion; go to WAIT.
- **WAIT:**
  - Watchdog increments each cycle.
  - On `kdf_complete` = 1, go to STORE.
  - If the watchdog reaches TIMEOUT-2 with no completion, go to IDLE. Pulse `err[g]` in that cycle. Entry g is untouched. The pointer advances to g+1.
- **STORE:**
  - Write `kdf_session_key` to entry g and set `key_valid[g]`.
  - Pulse `done[g]`; pointer = g+1 mod NUM_REQ; go to IDLE.
- **Latency:** start to done = KDF latency + 3 cycles. The nominal KDF takes 12 cycles from start to complete.
- **Operand stability:** `kdf_*` operand outputs are driven from the operand registers and stay stable from LAUNCH through STORE. Later changes on `req_*` have no effect.
- **Request retirement:** `req[g]` deasserted mid-operation is ignored; the operation completes and `done` still pulses.
- **Re-request:** a requester whose bit is still high after `done` is re-granted only after the other pending requesters, per round-robin.
- **Key overwrite:** re-deriving entry i overwrites it; `key_valid[i]` stays 1.
- **Read port:** `rd_key` <= key table[`rd_idx`] every cycle. `rd_idx` >= NUM_REQ returns 0. A same-cycle read and STORE to the same entry returns the old value.
- **Reset mid-operation:** FSM returns to IDLE and the table clears immediately. The KDF, sharing the same reset, also clears.

Optional Feature:
- **Macro:** KDF_ZEROIZE_EN.
- **Added port when defined:** `zeroize`  in  NUM_REQ.
- **Zeroize behaviour:** a set bit i clears entry i and `key_valid[i]` on the next edge.
- **Conflict with STORE:** if zeroize targets the entry being stored in the same cycle, zeroize wins and `done[g]` still pulses.
- **Pending requests:** a zeroize for an entry not in flight does not cancel pending requests.
- **When undefined:** the port is absent and entries persist until reset or overwrite.

Test Plan:
- **Single request:** `req[0]` with secret=0x11.., fpga=0x22.., client=0x44.. (KDF model = XOR) -> `kdf_start` one pulse; `done[0]` 15 cycles after start; `rd_idx`=0 gives 0x77.. next cycle; `key_valid`=0001.
- **Fairness:** `req`=1111 held continuously -> grants in order 0,1,2,3,0; exactly one `kdf_start` per grant, never overlapping.
- **Stale complete:** KDF `complete` still high from the previous job at LAUNCH -> no STORE before the fresh completion; stored key equals the new operands' result.
- **Timeout:** KDF stub never asserts complete, `req`=0100 -> `err[2]` pulses 65 cycles after LAUNCH; `key_valid[2]`=0; next grant goes to requester 3 if pending.
- **Reset mid-operation:** `reset_n` low during WAIT -> all outputs 0 asynchronously; after release, the re-issued request completes normally.
- **Zeroize (KDF_ZEROIZE_EN):** zeroize=0001 in the same cycle as STORE of entry 0 -> `done[0]`=1, `key_valid[0]`=0, `rd_key`=0.

Source files
------------

// File: rtl/kdf_session_scheduler_if.sv
// Host/KDF bus for kdf_session_scheduler: request operands, status pulses,
// the key read port and the shared KDF operand/result lines.
`timescale 1ns/1ps
interface kdf_session_scheduler_if #(
    parameter int unsigned NUM_REQ = 4
);
    localparam int unsigned KEY_W = 256;

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*KEY_W-1:0] req_secret;
    logic [NUM_REQ*KEY_W-1:0] req_nonce_fpga;
    logic [NUM_REQ*KEY_W-1:0] req_nonce_client;
    logic [NUM_REQ-1:0]       done;
    logic [NUM_REQ-1:0]       err;
    logic [NUM_REQ-1:0]       key_valid;
    logic [2:0]               rd_idx;
    logic [KEY_W-1:0]         rd_key;
    logic                     kdf_start;
    logic [KEY_W-1:0]         kdf_shared_secret;
    logic [KEY_W-1:0]         kdf_nonce_fpga;
    logic [KEY_W-1:0]         kdf_nonce_client;
    logic [KEY_W-1:0]         kdf_session_key;
    logic                     kdf_complete;
    logic                     busy;

    // Scheduler side
    modport slave (
        input  req, req_secret, req_nonce_fpga, req_nonce_client, rd_idx,
               kdf_session_key, kdf_complete,
        output done, err, key_valid, rd_key, kdf_start, kdf_shared_secret,
               kdf_nonce_fpga, kdf_nonce_client, busy
    );

    // Host channels and KDF side
    modport master (
        output req, req_secret, req_nonce_fpga, req_nonce_client, rd_idx,
               kdf_session_key, kdf_complete,
        input  done, err, key_valid, rd_key, kdf_start, kdf_shared_secret,
               kdf_nonce_fpga, kdf_nonce_client, busy
    );
endinterface

// File: rtl/kdf_session_scheduler.sv
// Round-robin scheduler sharing one KDF among NUM_REQ requesters, with a
// watchdog and a per-requester key table. Optional KDF_ZEROIZE_EN adds zeroize.
`timescale 1ns/1ps
module kdf_session_scheduler #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset_n,
`ifdef KDF_ZEROIZE_EN
    input  logic [NUM_REQ-1:0]  zeroize,
`endif
    kdf_session_scheduler_if.slave bus
);
    localparam int unsigned KEY_W = 256;
    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_SETTLE,
        S_WAIT,
        S_STORE
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] gnt;
    logic [WD_W-1:0]  wdog;
    logic [KEY_W-1:0] key_tbl [NUM_REQ];

    logic [IDX_W-1:0] pick_c;
    logic             pick_vld_c;
    logic [IDX_W-1:0] next_c;

    // First pending request at or after the pointer, wrapping.
    always_comb begin
        pick_c     = '0;
        pick_vld_c = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!pick_vld_c && bus.req[IDX_W'((32'(ptr) + k) % NUM_REQ)]) begin
                pick_vld_c = 1'b1;
                pick_c     = IDX_W'((32'(ptr) + k) % NUM_REQ);
            end
        end
    end

    assign next_c = (gnt == IDX_W'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                 <= S_IDLE;
            ptr                   <= '0;
            gnt                   <= '0;
            wdog                  <= '0;
            bus.kdf_start         <= 1'b0;
            bus.kdf_shared_secret <= '0;
            bus.kdf_nonce_fpga    <= '0;
            bus.kdf_nonce_client  <= '0;
            bus.done              <= '0;
            bus.err               <= '0;
            bus.key_valid         <= '0;
            bus.rd_key            <= '0;
            bus.busy              <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) key_tbl[i] <= '0;
        end else begin
            bus.kdf_start <= 1'b0;
            bus.done      <= '0;
            bus.err       <= '0;

            // Read samples the table before this edge's write: old value on collision.
            if (32'(bus.rd_idx) < NUM_REQ) bus.rd_key <= key_tbl[bus.rd_idx[IDX_W-1:0]];
            else                           bus.rd_key <= '0;

            case (state)
                S_IDLE: begin
                    if (pick_vld_c) begin
                        gnt                   <= pick_c;
                        bus.kdf_shared_secret <= bus.req_secret[32'(pick_c)*KEY_W +: KEY_W];
                        bus.kdf_nonce_fpga    <= bus.req_nonce_fpga[32'(pick_c)*KEY_W +: KEY_W];
                        bus.kdf_nonce_client  <= bus.req_nonce_client[32'(pick_c)*KEY_W +: KEY_W];
                        bus.kdf_start         <= 1'b1;
                        bus.busy              <= 1'b1;
                        state                 <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    wdog  <= '0;
                    state <= S_SETTLE;
                end
                // KDF still presents the previous job's completion here.
                S_SETTLE: state <= S_WAIT;
                S_WAIT: begin
                    if (bus.kdf_complete) begin
                        state <= S_STORE;
                    end else if (wdog == WD_W'(TIMEOUT - 2)) begin
                        bus.err[gnt] <= 1'b1;
                        ptr          <= next_c;
                        bus.busy     <= 1'b0;
                        state        <= S_IDLE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                S_STORE: begin
                    key_tbl[gnt]       <= bus.kdf_session_key;
                    bus.key_valid[gnt] <= 1'b1;
                    bus.done[gnt]      <= 1'b1;
                    ptr                <= next_c;
                    bus.busy           <= 1'b0;
                    state              <= S_IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase

`ifdef KDF_ZEROIZE_EN
            // Applied last so it overrides a same-cycle store.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (zeroize[i]) begin
                    key_tbl[i]       <= '0;
                    bus.key_valid[i] <= 1'b0;
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_kdf_session_scheduler.sv
// Directed bench for kdf_session_scheduler with an XOR KDF stub that holds
// its completion level until the next job is underway.
`timescale 1ns/1ps
module tb_kdf_session_scheduler;
    logic clk = 1'b0;
    logic reset_n;
    bit   hang;
`ifdef KDF_ZEROIZE_EN
    logic [3:0] zeroize = '0;
`endif

    kdf_session_scheduler_if #(.NUM_REQ(4)) bus ();

    kdf_session_scheduler #(.NUM_REQ(4), .TIMEOUT(64)) dut (
        .clk     (clk),
        .reset_n (reset_n),
`ifdef KDF_ZEROIZE_EN
        .zeroize (zeroize),
`endif
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;
    int ncyc = 0;
    int starts = 0;
    int start_cyc = 0;
    bit start_seen = 1'b0;
    logic [255:0] last_sec;
    logic [255:0] sec [4];
    logic [255:0] cli [4];
    logic [255:0] fpga;
    logic [255:0] kexp [4];
    logic [255:0] sec1b, k1b;

    // KDF stub: XOR of operands, complete 13 negedges after start is seen.
    initial begin
        bit kbusy = 1'b0;
        int cnt = 0;
        logic [255:0] op = '0;
        bus.kdf_complete    = 1'b0;
        bus.kdf_session_key = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                kbusy = 1'b0;
                cnt   = 0;
                bus.kdf_complete    = 1'b0;
                bus.kdf_session_key = '0;
            end else if (bus.kdf_start) begin
                kbusy = 1'b1;
                cnt   = 0;
                op    = bus.kdf_shared_secret ^ bus.kdf_nonce_fpga ^ bus.kdf_nonce_client;
            end else if (kbusy) begin
                cnt++;
                if (cnt == 2) bus.kdf_complete = 1'b0;
                if (cnt == 13 && !hang) begin
                    bus.kdf_complete    = 1'b1;
                    bus.kdf_session_key = op;
                    kbusy = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        ncyc++;
        if (bus.kdf_start) begin
            starts++;
            start_seen = 1'b1;
            start_cyc  = ncyc;
            last_sec   = bus.kdf_shared_secret;
        end
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (!start_seen && n < 60) begin
            step();
            n++;
        end
        check({tag, " start"}, 256'(start_seen), 256'(1));
        start_seen = 1'b0;
    endtask

    task automatic wait_event(input string tag, input int lat, input logic [3:0] exp_done,
                              input logic [3:0] exp_err);
        int n = 0;
        int s0 = starts;
        while (bus.done == '0 && bus.err == '0 && n < 120) begin
            step();
            n++;
        end
        check({tag, " latency"}, 256'(ncyc - start_cyc), 256'(lat));
        check({tag, " done"}, 256'(bus.done), 256'(exp_done));
        check({tag, " err"}, 256'(bus.err), 256'(exp_err));
        check({tag, " overlap"}, 256'(starts - s0), 256'(0));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        start_seen = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL global timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset_n = 1'b0;
        hang    = 1'b0;
        fpga    = {32{8'h22}};
        sec[0]  = {32{8'h11}}; cli[0] = {32{8'h44}}; kexp[0] = {32{8'h77}};
        sec[1]  = {32{8'h12}}; cli[1] = {32{8'h48}}; kexp[1] = {32{8'h78}};
        sec[2]  = {32{8'h13}}; cli[2] = {32{8'h50}}; kexp[2] = {32{8'h61}};
        sec[3]  = {32{8'h14}}; cli[3] = {32{8'h60}}; kexp[3] = {32{8'h56}};
        sec1b   = {32{8'h5A}}; k1b    = {32{8'h30}};
        bus.req    = '0;
        bus.rd_idx = '0;
        for (int i = 0; i < 4; i++) begin
            bus.req_secret[256*i +: 256]       = sec[i];
            bus.req_nonce_fpga[256*i +: 256]   = fpga;
            bus.req_nonce_client[256*i +: 256] = cli[i];
        end
        step();
        step();

        check("rst busy", 256'(bus.busy), 256'(0));
        check("rst done", 256'(bus.done), 256'(0));
        check("rst err", 256'(bus.err), 256'(0));
        check("rst key_valid", 256'(bus.key_valid), 256'(0));
        check("rst kdf_start", 256'(bus.kdf_start), 256'(0));
        check("rst rd_key", bus.rd_key, 256'(0));
        check("rst secret", bus.kdf_shared_secret, 256'(0));
        reset_n = 1'b1;

        // Single request
        bus.req = 4'b0001;
        wait_start("single");
        check("single secret", last_sec, sec[0]);
        check("single fpga", bus.kdf_nonce_fpga, fpga);
        check("single client", bus.kdf_nonce_client, cli[0]);
        check("single busy", 256'(bus.busy), 256'(1));
        wait_event("single", 15, 4'b0001, 4'b0000);
        bus.req = '0;
        bus.rd_idx = 3'd0;
        check("single key_valid", 256'(bus.key_valid), 256'(4'b0001));
        step();
        check("single rd_key", bus.rd_key, kexp[0]);
        check("single idle", 256'(bus.busy), 256'(0));
        bus.rd_idx = 3'd5;
        step();
        check("rd out of range", bus.rd_key, 256'(0));
        bus.rd_idx = 3'd1;
        step();
        check("rd empty entry", bus.rd_key, 256'(0));

        // Fairness with all requests held
        do_reset();
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_start($sformatf("fair%0d", k));
            check($sformatf("fair%0d grant", k), last_sec, sec[k % 4]);
            wait_event($sformatf("fair%0d", k), 15, 4'(1 << (k % 4)), 4'b0000);
        end
        bus.req = '0;
        check("fair key_valid", 256'(bus.key_valid), 256'(4'b1111));
        bus.rd_idx = 3'd3;
        step();
        check("fair rd_key3", bus.rd_key, kexp[3]);

        // Stale completion, operand stability, retirement, overwrite
        bus.req_secret[256 +: 256] = sec1b;
        bus.req = 4'b0010;
        wait_start("stale");
        check("stale grant", last_sec, sec1b);
        bus.req_secret[256 +: 256] = '1;
        bus.req = '0;
        step();
        step();
        check("stale operand hold", bus.kdf_shared_secret, sec1b);
        wait_event("stale", 15, 4'b0010, 4'b0000);
        bus.req_secret[256 +: 256] = sec[1];
        bus.rd_idx = 3'd1;
        check("overwrite key_valid", 256'(bus.key_valid), 256'(4'b1111));
        step();
        check("overwrite rd_key", bus.rd_key, k1b);

        // Watchdog timeout, then pointer advance past the timed-out requester
        do_reset();
        hang = 1'b1;
        bus.req = 4'b1100;
        wait_start("timeout");
        check("timeout grant", last_sec, sec[2]);
        wait_event("timeout", 65, 4'b0000, 4'b0100);
        hang = 1'b0;
        check("timeout key_valid", 256'(bus.key_valid), 256'(0));
        bus.rd_idx = 3'd2;
        step();
        check("timeout rd_key", bus.rd_key, 256'(0));
        wait_start("post-timeout");
        check("post-timeout grant", last_sec, sec[3]);
        wait_event("post-timeout", 15, 4'b1000, 4'b0000);
        bus.req = 4'b0100;
        wait_start("retry");
        check("retry grant", last_sec, sec[2]);
        wait_event("retry", 15, 4'b0100, 4'b0000);
        bus.req = '0;
        check("retry key_valid", 256'(bus.key_valid), 256'(4'b1100));
        step();
        check("retry rd_key", bus.rd_key, kexp[2]);

        // Asynchronous reset during WAIT
        bus.req = 4'b0001;
        wait_start("midreset");
        repeat (5) step();
        check("midreset busy", 256'(bus.busy), 256'(1));
        #2;
        reset_n = 1'b0;
        #1;
        check("midreset busy low", 256'(bus.busy), 256'(0));
        check("midreset key_valid", 256'(bus.key_valid), 256'(0));
        check("midreset secret", bus.kdf_shared_secret, 256'(0));
        check("midreset rd_key", bus.rd_key, 256'(0));
        step();
        reset_n = 1'b1;
        start_seen = 1'b0;
        wait_start("reissue");
        check("reissue grant", last_sec, sec[0]);
        wait_event("reissue", 15, 4'b0001, 4'b0000);
        bus.req = '0;
        bus.rd_idx = 3'd0;
        step();
        check("reissue rd_key", bus.rd_key, kexp[0]);

`ifdef KDF_ZEROIZE_EN
        // Zeroize colliding with STORE of the same entry
        bus.req = 4'b0001;
        wait_start("zeroize");
        repeat (14) step();
        zeroize = 4'b0001;
        step();
        check("zeroize done", 256'(bus.done), 256'(4'b0001));
        check("zeroize key_valid", 256'(bus.key_valid), 256'(0));
        zeroize = '0;
        bus.req = '0;
        step();
        step();
        check("zeroize rd_key", bus.rd_key, 256'(0));
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
